// File: rtl/sqrt_pkg.sv
// rtl/sqrt_pkg.sv - shared FSM state type and default parameters for the square-root unit
package sqrt_pkg;

  localparam int SQRT_WIDTH = 16;
  localparam int SQRT_ROUND = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sqrt_step.sv
// rtl/sqrt_step.sv - one restoring square-root iteration: trial subtract, select, shift
module sqrt_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH/2:0]   rem_in,
  input  logic [WIDTH/2-1:0] root_in,
  input  logic [1:0]         pair,
  output logic [WIDTH/2:0]   rem_out,
  output logic [WIDTH/2-1:0] root_out
);

  localparam int H  = WIDTH / 2;
  localparam int RW = H + 3;

  logic [RW-1:0] shifted;
  logic [RW-1:0] trial;
  logic [RW-1:0] diff;
  logic          unused_diff;

  assign shifted = {rem_in, pair};
  assign trial   = {1'b0, root_in, 2'b01};
  assign diff    = shifted - trial;

  // The surviving remainder never exceeds 2r, so only its low H+1 bits are live.
  assign unused_diff = ^diff[RW-1:H+1];

  always_comb begin
    if (shifted >= trial) begin
      rem_out  = diff[H:0];
      root_out = {root_in[H-2:0], 1'b1};
    end else begin
      rem_out  = shifted[H:0];
      root_out = {root_in[H-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/sqrt_unit.sv
// rtl/sqrt_unit.sv - iterative integer square root, one root bit per cycle, optional rounding
module sqrt_unit
  import sqrt_pkg::*;
#(
  parameter int WIDTH = SQRT_WIDTH,
  parameter int ROUND = SQRT_ROUND
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [WIDTH-1:0]   Operand,
  output logic [WIDTH/2-1:0] Root,
  output logic [WIDTH/2:0]   Remainder,
  output logic               Busy,
  output logic               Ack
);

  localparam int H  = WIDTH / 2;
  localparam int CW = $clog2(H) + 1;
  localparam logic [CW-1:0] LAST = CW'(H - 1);

  state_t state;
  state_t next_state;

  logic             accept;
  logic             last;
  logic [WIDTH-1:0] x_q;
  logic [H:0]       rem_q;
  logic [H-1:0]     part_q;
  logic [CW-1:0]    cnt_q;
  logic [H-1:0]     root_q;
  logic [H:0]       remd_q;
  logic [H:0]       step_rem;
  logic [H-1:0]     step_root;
  logic [H-1:0]     rounded;

  assign accept = Start && (state == IDLE || state == DONE);
  assign last   = (cnt_q == LAST);

  sqrt_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .root_in (part_q),
    .pair    (x_q[WIDTH-1:WIDTH-2]),
    .rem_out (step_rem),
    .root_out(step_root)
  );

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = RUN;
      RUN:     if (last)   next_state = DONE;
      DONE:    next_state = accept ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    Busy      = 1'b0;
    Ack       = 1'b0;
    Root      = root_q;
    Remainder = remd_q;
    if (Reset) begin
      Root      = '0;
      Remainder = '0;
    end else begin
      Busy = (state == RUN);
      Ack  = (state == DONE);
    end
  end

  // Round up when the floor remainder exceeds r, but never wrap an all-ones root.
  always_comb begin
    rounded = step_root;
    if (ROUND != 0 && ({1'b0, step_root} < step_rem) && (step_root != '1))
      rounded = step_root + H'(1);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      x_q    <= '0;
      rem_q  <= '0;
      part_q <= '0;
      cnt_q  <= '0;
      root_q <= '0;
      remd_q <= '0;
    end else if (accept) begin
      x_q    <= Operand;
      rem_q  <= '0;
      part_q <= '0;
      cnt_q  <= '0;
    end else if (state == RUN) begin
      x_q    <= {x_q[WIDTH-3:0], 2'b00};
      rem_q  <= step_rem;
      part_q <= step_root;
      cnt_q  <= cnt_q + CW'(1);
      if (last) begin
        root_q <= rounded;
        remd_q <= step_rem;
      end
    end
  end

endmodule

// File: tb/tb_sqrt_unit.sv
// tb/tb_sqrt_unit.sv - table and scoreboard bench for sqrt_unit at 16/32 bits, floor and rounded
module tb_sqrt_unit;

  typedef struct {
    logic [15:0] op;
    logic [7:0]  r0;
    logic [7:0]  r1;
    logic [8:0]  rem;
  } vec16_t;

  typedef struct {
    logic [31:0] op;
    logic [15:0] r;
    logic [16:0] rem;
  } vec32_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start16 = 1'b0;
  logic [15:0] op16 = '0;
  logic        start32 = 1'b0;
  logic [31:0] op32 = '0;

  logic [7:0]  root_a, root_b;
  logic [8:0]  rem_a, rem_b;
  logic        busy_a, busy_b, ack_a, ack_b;
  logic [15:0] root_c;
  logic [16:0] rem_c;
  logic        busy_c, ack_c;

  int pass_n = 0;
  int total_n = 0;

  vec16_t exp_q16[$];
  vec32_t exp_q32[$];
  vec16_t mv16;
  vec32_t mv32;
  vec16_t tbl[13];

  always #5 clk = ~clk;

  sqrt_unit #(.WIDTH(16), .ROUND(0)) dut_a (
    .Clk(clk), .Reset(reset), .Start(start16), .Operand(op16),
    .Root(root_a), .Remainder(rem_a), .Busy(busy_a), .Ack(ack_a)
  );

  sqrt_unit #(.WIDTH(16), .ROUND(1)) dut_b (
    .Clk(clk), .Reset(reset), .Start(start16), .Operand(op16),
    .Root(root_b), .Remainder(rem_b), .Busy(busy_b), .Ack(ack_b)
  );

  sqrt_unit #(.WIDTH(32), .ROUND(0)) dut_c (
    .Clk(clk), .Reset(reset), .Start(start32), .Operand(op32),
    .Root(root_c), .Remainder(rem_c), .Busy(busy_c), .Ack(ack_c)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_n++;
    if (act !== exp)
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    else
      pass_n++;
  endtask

  function automatic vec16_t model16(input logic [15:0] op);
    vec16_t v;
    int r = 0;
    int rem;
    while ((r + 1) * (r + 1) <= int'(op)) r++;
    rem = int'(op) - r * r;
    v.op  = op;
    v.r0  = 8'(r);
    v.r1  = (rem > r && r != 255) ? 8'(r + 1) : 8'(r);
    v.rem = 9'(rem);
    return v;
  endfunction

  // Scoreboard: every Ack pops the oldest expected result.
  always @(negedge clk) begin
    if (!reset) begin
      if (ack_a) begin
        check("ack_b_with_a", 64'(ack_b), 64'(1));
        if (exp_q16.size() == 0) begin
          check("ack16_unexpected", 64'(ack_a), 64'(0));
        end else begin
          mv16 = exp_q16.pop_front();
          check("root16_floor", 64'(root_a), 64'(mv16.r0));
          check("rem16_floor", 64'(rem_a), 64'(mv16.rem));
          check("root16_round", 64'(root_b), 64'(mv16.r1));
          check("rem16_round", 64'(rem_b), 64'(mv16.rem));
        end
      end
      if (ack_c) begin
        if (exp_q32.size() == 0) begin
          check("ack32_unexpected", 64'(ack_c), 64'(0));
        end else begin
          mv32 = exp_q32.pop_front();
          check("root32", 64'(root_c), 64'(mv32.r));
          check("rem32", 64'(rem_c), 64'(mv32.rem));
        end
      end
    end
  end

  task automatic wait_ack16(output int lat, output int busy_n);
    lat = 0;
    busy_n = int'(busy_a);
    while (!ack_a && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (busy_a) busy_n++;
    end
  endtask

  task automatic run16(input vec16_t v);
    int lat, busy_n;
    @(negedge clk);
    start16 = 1'b1;
    op16 = v.op;
    exp_q16.push_back(v);
    @(posedge clk); #1;
    start16 = 1'b0;
    op16 = ~v.op;
    wait_ack16(lat, busy_n);
    check("lat16", 64'(lat), 64'(8));
    check("busy16_cycles", 64'(busy_n), 64'(8));
    @(posedge clk); #1;
    check("ack16_one_cycle", 64'(ack_a), 64'(0));
  endtask

  task automatic run32(input vec32_t v);
    int lat;
    @(negedge clk);
    start32 = 1'b1;
    op32 = v.op;
    exp_q32.push_back(v);
    @(posedge clk); #1;
    start32 = 1'b0;
    op32 = ~v.op;
    lat = 0;
    while (!ack_c && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    check("lat32", 64'(lat), 64'(16));
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0t required=finish", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int lat, busy_n, acks;
    vec32_t w;

    tbl[0]  = '{16'd36864, 8'd192, 8'd192, 9'd0};
    tbl[1]  = '{16'd65535, 8'd255, 8'd255, 9'd510};
    tbl[2]  = '{16'd12,    8'd3,   8'd3,   9'd3};
    tbl[3]  = '{16'd13,    8'd3,   8'd4,   9'd4};
    tbl[4]  = '{16'd2,     8'd1,   8'd1,   9'd1};
    tbl[5]  = '{16'd0,     8'd0,   8'd0,   9'd0};
    tbl[6]  = '{16'd1,     8'd1,   8'd1,   9'd0};
    tbl[7]  = '{16'd65025, 8'd255, 8'd255, 9'd0};
    tbl[8]  = '{16'd100,   8'd10,  8'd10,  9'd0};
    tbl[9]  = '{16'd110,   8'd10,  8'd10,  9'd10};
    tbl[10] = '{16'd111,   8'd10,  8'd11,  9'd11};
    tbl[11] = '{16'd65280, 8'd255, 8'd255, 9'd255};
    tbl[12] = '{16'd65281, 8'd255, 8'd255, 9'd256};

    repeat (3) @(posedge clk);
    #1;
    check("reset_root", 64'(root_a), 64'(0));
    check("reset_rem", 64'(rem_a), 64'(0));
    check("reset_busy", 64'(busy_a), 64'(0));
    check("reset_ack", 64'(ack_a), 64'(0));
    check("reset_busy32", 64'(busy_c), 64'(0));
    reset = 1'b0;

    for (int i = 0; i < 13; i++) run16(tbl[i]);
    for (int i = 0; i < 6; i++) run16(model16(16'($urandom)));

    w = '{32'hFFFF_FFFF, 16'd65535, 17'd131070}; run32(w);
    w = '{32'd0,         16'd0,     17'd0};      run32(w);
    w = '{32'h4000_0000, 16'd32768, 17'd0};      run32(w);
    w = '{32'd1000001,   16'd1000,  17'd1};      run32(w);

    // Start held through RUN with a new operand, then through DONE.
    @(negedge clk);
    start16 = 1'b1;
    op16 = 16'd36864;
    exp_q16.push_back(tbl[0]);
    @(posedge clk); #1;
    op16 = 16'd100;
    exp_q16.push_back(tbl[8]);
    wait_ack16(lat, busy_n);
    check("b2b_lat_first", 64'(lat), 64'(8));
    @(posedge clk); #1;
    check("b2b_no_idle", 64'(busy_a), 64'(1));
    start16 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("hold_root_in_run", 64'(root_a), 64'(192));
    wait_ack16(lat, busy_n);
    check("b2b_lat_second", 64'(lat), 64'(5));

    // Abort three cycles into RUN.
    @(negedge clk);
    start16 = 1'b1;
    op16 = 16'd36864;
    @(posedge clk); #1;
    start16 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("abort_root", 64'(root_a), 64'(0));
    check("abort_rem", 64'(rem_a), 64'(0));
    check("abort_busy", 64'(busy_a), 64'(0));
    check("abort_ack", 64'(ack_a), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("abort_idle_busy", 64'(busy_a), 64'(0));
    check("abort_idle_root", 64'(root_a), 64'(0));
    acks = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (ack_a) acks++;
    end
    check("abort_no_ack", 64'(acks), 64'(0));
    run16(tbl[0]);

    repeat (3) @(posedge clk);
    check("q16_drained", 64'(exp_q16.size()), 64'(0));
    check("q32_drained", 64'(exp_q32.size()), 64'(0));

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule

// File: doc/sqrt_unit.md
SQRT_UNIT -- requirements
Module: sqrt_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits; even, 4..64.
REQ-002 SHALL have parameter ROUND, default 0; 0 = floor result, 1 = round-to-nearest with saturation.
REQ-003 SHALL have port Clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port Start  input  1  request; sampled on the rising edge of Clk.
REQ-006 SHALL have port Operand  input  WIDTH  unsigned radicand; sampled only with an accepted Start.
REQ-007 SHALL have port Root  output  WIDTH/2  unsigned square-root result.
REQ-008 SHALL have port Remainder  output  WIDTH/2+1  Operand minus floor-root squared.
REQ-009 SHALL have port Busy  output  1  high while an operation is in progress.
REQ-010 SHALL have port Ack  output  1  one-cycle completion pulse; Root and Remainder are valid with it.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, RUN and DONE.
REQ-012 SHALL accept Start only in IDLE or DONE; on acceptance it SHALL capture Operand, clear the partial root, remainder and iteration counter, and enter RUN.
REQ-013 SHALL ignore Start while in RUN, leaving the in-flight operation and Operand capture unaffected.
REQ-014 SHALL use restoring digit-by-digit recurrence in RUN, producing one root bit per cycle, MSB first, for exactly WIDTH/2 cycles.
REQ-015 SHALL, on the WIDTH/2-th RUN edge, register Root and Remainder, enter DONE and assert Ack; latency is WIDTH/2 cycles from the Start-capture edge (8 for WIDTH=16).
REQ-016 SHALL hold Ack high for exactly one cycle (DONE), then return to IDLE unless a new Start is accepted in DONE, which gives back-to-back operation.
REQ-017 SHALL hold Root and Remainder stable from Ack until the next Ack or Reset, including while a following operation is in RUN.
REQ-018 SHALL assert Busy in RUN only, and deassert it in IDLE and DONE.
REQ-019 SHALL return Remainder as Operand minus r squared, where r is the floor root; Remainder SHALL always lie in 0..2r and SHALL always be the floor remainder, independent of ROUND.
REQ-020 SHALL, when ROUND=1, output Root = r+1 if Remainder > r, otherwise r.
REQ-021 SHALL, when ROUND=1, saturate Root at all-ones when r is already all-ones; Root SHALL never wrap.
REQ-022 SHALL, when ROUND=0, output Root = r.
REQ-023 SHALL treat Operand=0 with no special path; the result SHALL be 0 with remainder 0 and the same latency.
REQ-024 SHALL keep all internal arithmetic at least WIDTH/2+2 bits wide, so the trial subtraction never overflows.

Reset
REQ-025 SHALL, while Reset is high, place the FSM in IDLE and drive Root, Remainder, Busy and Ack to 0, with Start ignored.
REQ-026 SHALL allow Reset mid-RUN to abort the operation with no Ack; the next Start after Reset deasserts SHALL behave as from power-up.
REQ-027 SHALL give Reset priority over a Start sampled on the same edge.

Structure
REQ-028 SHALL place the FSM state enum (IDLE/RUN/DONE) and the default WIDTH/ROUND constants in shared package sqrt_pkg.
REQ-029 SHALL place one recurrence iteration (trial subtract, select, shift) in combinational sub-module sqrt_step, parametrised by WIDTH.
REQ-030 SHALL keep the FSM, counter and output registers in sqrt_unit; no multipliers or dividers SHALL be inferred.

Verification
REQ-031 SHALL cover: WIDTH=16, ROUND=0, Operand=36864 -> Ack 8 cycles after capture, Root=192 (0xC0), Remainder=0, Busy high for 8 cycles.
REQ-032 SHALL cover: WIDTH=16, Operand=65535 -> ROUND=0 gives Root=255, Remainder=510; ROUND=1 gives Root=255 (saturated, no wrap).
REQ-033 SHALL cover: WIDTH=16, ROUND=1, Operands 12, 13, 2, 0 -> Root 3, 4, 1, 0 and Remainder 3, 4, 1, 0.
REQ-034 SHALL cover: WIDTH=32, ROUND=0, Operand=0xFFFFFFFF -> Root=65535, Remainder=131070, Ack 16 cycles after capture.
REQ-035 SHALL cover: Start in RUN with a different Operand -> ignored, original result returned; Start held high in DONE -> second operation starts with no idle cycle.
REQ-036 SHALL cover: Reset 3 cycles into RUN -> no Ack, all outputs 0, FSM in IDLE; next Start with 36864 -> Root=192.
